// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and constants for the DDR read-channel arbiter.
package ddr_arb_pkg;
  localparam int NumMasters = 2;
  localparam int AddrW = 32;
  localparam int DataW = 32;
  localparam int SIdW = 5;
  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [SIdW:0]    id;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
  } ar_req_t;
  typedef struct packed {
    logic [DataW-1:0] data;
    logic [SIdW-1:0]  id;
    logic [1:0]       resp;
    logic             last;
  } r_rsp_t;
  typedef enum logic {IDLE, SEND} arb_state_e;
endpackage

// File: rtl/ddr_rd_arb_rr.sv
// ddr_rd_arb_rr: 2-way round-robin picker; prio moves to the loser on each enabled grant.
module ddr_rd_arb_rr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_elig,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_idx
);
  logic r_prio;
  assign o_idx = i_elig[r_prio] ? r_prio : ~r_prio;
  assign o_gnt = i_elig[o_idx] ? (o_idx ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_prio <= 1'b0;
    else if (i_en) r_prio <= ~o_idx;
endmodule

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: 2:1 AXI4 read arbiter with registered AR stage and ID-prefix R routing.
// Define DDR_RD_ARB_ERR_EN to flag and drop R beats arriving with no burst outstanding.
module ddr_rd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int AddrWidth      = AddrW,
  parameter int DataWidth      = DataW,
  parameter int SIdWidth       = SIdW,
  parameter int MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumMasters-1:0]                s_ar_valid,
  output logic [NumMasters-1:0]                s_ar_ready,
  input  logic [NumMasters-1:0][AddrWidth-1:0] s_ar_addr,
  input  logic [NumMasters-1:0][SIdWidth-1:0]  s_ar_id,
  input  logic [NumMasters-1:0][7:0]           s_ar_len,
  input  logic [NumMasters-1:0][2:0]           s_ar_size,
  input  logic [NumMasters-1:0][1:0]           s_ar_burst,
  output logic [NumMasters-1:0]                s_r_valid,
  input  logic [NumMasters-1:0]                s_r_ready,
  output logic [DataWidth-1:0]                 s_r_data,
  output logic [SIdWidth-1:0]                  s_r_id,
  output logic [1:0]                           s_r_resp,
  output logic                                 s_r_last,
  output logic                                 m_ar_valid,
  input  logic                                 m_ar_ready,
  output logic [AddrWidth-1:0]                 m_ar_addr,
  output logic [SIdWidth:0]                    m_ar_id,
  output logic [7:0]                           m_ar_len,
  output logic [2:0]                           m_ar_size,
  output logic [1:0]                           m_ar_burst,
  input  logic                                 m_r_valid,
  output logic                                 m_r_ready,
  input  logic [DataWidth-1:0]                 m_r_data,
  input  logic [SIdWidth:0]                    m_r_id,
  input  logic [1:0]                           m_r_resp,
  input  logic                                 m_r_last,
  output logic                                 err_o
);
  arb_state_e                  r_state, w_state_nxt;
  ar_req_t                     r_ar;
  r_rsp_t                      w_rsp;
  logic [NumMasters-1:0][3:0]  r_cnt;
  logic [NumMasters-1:0]       w_elig, w_gnt;
  logic                        w_idx, w_take, w_gnt_en, w_src, w_orphan, w_rdone;
  always_comb
    for (int i = 0; i < NumMasters; i++)
      w_elig[i] = s_ar_valid[i] && (r_cnt[i] < 4'(MaxOutstanding));
  // The AR slot is free when empty or when its current beat is being taken downstream.
  assign w_take   = (r_state == IDLE) || m_ar_ready;
  assign w_gnt_en = w_take && |w_elig;
  ddr_rd_arb_rr u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_elig(w_elig),
    .i_en  (w_gnt_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );
  assign s_ar_ready = w_take ? w_gnt : '0;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_gnt_en ? SEND : (m_ar_ready ? IDLE : r_state);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_ar <= '0;
    else if (w_gnt_en) r_ar <= '{addr: s_ar_addr[w_idx], id: {w_idx, s_ar_id[w_idx]},
                                 len: s_ar_len[w_idx], size: s_ar_size[w_idx],
                                 burst: s_ar_burst[w_idx]};
  assign m_ar_valid = (r_state == SEND);
  assign m_ar_addr  = r_ar.addr;
  assign m_ar_id    = r_ar.id;
  assign m_ar_len   = r_ar.len;
  assign m_ar_size  = r_ar.size;
  assign m_ar_burst = r_ar.burst;
  assign w_src = m_r_id[SIdWidth];
`ifdef DDR_RD_ARB_ERR_EN
  logic r_err;
  assign w_orphan = (r_cnt[w_src] == 4'd0);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_err <= 1'b0;
    else r_err <= r_err | (m_r_valid & w_orphan);
  assign err_o = r_err;
`else
  assign w_orphan = 1'b0;
  assign err_o    = 1'b0;
`endif
  assign w_rsp     = '{data: m_r_data, id: m_r_id[SIdWidth-1:0], resp: m_r_resp, last: m_r_last};
  assign s_r_data  = w_rsp.data;
  assign s_r_id    = w_rsp.id;
  assign s_r_resp  = w_rsp.resp;
  assign s_r_last  = w_rsp.last;
  assign s_r_valid = (m_r_valid && !w_orphan) ? (w_src ? 2'b10 : 2'b01) : 2'b00;
  assign m_r_ready = s_r_ready[w_src] || w_orphan;
  // Zero check makes the counter saturate when orphan beats are routed through.
  assign w_rdone = m_r_valid && m_r_ready && m_r_last && (r_cnt[w_src] != 4'd0);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_cnt <= '0;
    else
      for (int i = 0; i < NumMasters; i++)
        r_cnt[i] <= r_cnt[i] + 4'(w_gnt_en & w_gnt[i]) - 4'(w_rdone & (w_src == 1'(i)));
endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed self-checking bench for ddr_rd_arbiter.
module tb_ddr_rd_arbiter;
  logic             clk = 1'b0, rst;
  logic [1:0]       s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
  logic [1:0][31:0] s_ar_addr;
  logic [1:0][4:0]  s_ar_id;
  logic [1:0][7:0]  s_ar_len;
  logic [1:0][2:0]  s_ar_size;
  logic [1:0][1:0]  s_ar_burst;
  logic [31:0]      s_r_data, m_ar_addr, m_r_data;
  logic [4:0]       s_r_id;
  logic [1:0]       s_r_resp, m_ar_burst, m_r_resp;
  logic             s_r_last, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, err_o;
  logic [5:0]       m_ar_id, m_r_id;
  logic [7:0]       m_ar_len;
  logic [2:0]       m_ar_size;
  int checks = 0, failures = 0;
  logic [1:0] e_rdy [11] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
  logic       e_mav [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
  logic [5:0] e_mid [11] = '{6'h3F, 6'h0A, 6'h2B, 6'h0A, 6'h2B, 6'h0A, 6'h2B, 6'h0A, 6'h0A, 6'h00, 6'h2B};
  logic [3:0] e_c0  [11] = '{0, 1, 1, 2, 2, 3, 3, 3, 4, 4, 4};
  logic [3:0] e_c1  [11] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 3, 4};
  ddr_rd_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; s_ar_valid = '0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0;
    s_ar_size = '0; s_ar_burst = '0; s_r_ready = '0; m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_data = '0; m_r_id = '0; m_r_resp = '0; m_r_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_ar_valid", m_ar_valid, 0);
    chk("rst_s_ar_ready", s_ar_ready, 0);
    chk("rst_err", err_o, 0);
    chk("rst_s_r_valid", s_r_valid, 0);
    tick(); rst = 1'b0;
    s_ar_valid = 2'b01; s_ar_addr[0] = 32'h8000_0000; s_ar_id[0] = 5'h03;
    s_ar_len[0] = 8'd3; s_ar_size[0] = 3'd2; s_ar_burst[0] = 2'd1;
    @(negedge clk);
    chk("single_s_ar_ready", s_ar_ready, 2'b01);
    tick(); s_ar_valid = 2'b00;
    @(negedge clk);
    chk("single_m_ar_valid", m_ar_valid, 1);
    chk("single_m_ar_id", m_ar_id, 6'h03);
    chk("single_m_ar_addr", m_ar_addr, 32'h8000_0000);
    chk("single_m_ar_len", m_ar_len, 3);
    chk("single_cnt0", dut.r_cnt[0], 1);
    tick(); m_ar_ready = 1'b1;
    tick(); m_ar_ready = 1'b0;
    @(negedge clk);
    chk("single_idle", m_ar_valid, 0);
    tick(); s_r_ready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_r_valid = 1'b1; m_r_id = 6'h03; m_r_data = 32'hD000 + b; m_r_last = (b == 3);
      @(negedge clk);
      chk("beat_s_r_valid", s_r_valid, 2'b01);
      chk("beat_s_r_id", s_r_id, 5'h03);
      chk("beat_s_r_data", s_r_data, 32'hD000 + b);
      chk("beat_m_r_ready", m_r_ready, 1);
      chk("beat_cnt0", dut.r_cnt[0], 1);
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    chk("after_last_cnt0", dut.r_cnt[0], 0);
    chk("no_beat_s_r_valid", s_r_valid, 2'b00);
    tick();
    s_ar_valid = 2'b10; s_ar_addr[1] = 32'h1234; s_ar_id[1] = 5'h1F; s_ar_len[1] = 8'd7;
    @(negedge clk);
    chk("m1_s_ar_ready", s_ar_ready, 2'b10);
    tick();
    s_ar_valid = 2'b11; s_ar_addr[0] = 32'h100; s_ar_id[0] = 5'h0A; s_ar_len[0] = 8'd0;
    s_ar_addr[1] = 32'h200; s_ar_id[1] = 5'h0B; s_ar_len[1] = 8'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_s_ar_ready", s_ar_ready, 2'b00);
      chk("bp_m_ar_valid", m_ar_valid, 1);
      chk("bp_m_ar_addr", m_ar_addr, 32'h1234);
      chk("bp_m_ar_id", m_ar_id, 6'h3F);
      chk("bp_m_ar_len", m_ar_len, 7);
      tick();
    end
    m_ar_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      m_r_valid = (k == 6 || k == 8); m_r_last = m_r_valid;
      m_r_id = (k == 8) ? 6'h2B : 6'h0A;
      @(negedge clk);
      chk($sformatf("rr_s_ar_ready[%0d]", k), s_ar_ready, e_rdy[k]);
      chk($sformatf("rr_m_ar_valid[%0d]", k), m_ar_valid, e_mav[k]);
      if (e_mav[k]) chk($sformatf("rr_m_ar_id[%0d]", k), m_ar_id, e_mid[k]);
      chk($sformatf("rr_cnt0[%0d]", k), dut.r_cnt[0], e_c0[k]);
      chk($sformatf("rr_cnt1[%0d]", k), dut.r_cnt[1], e_c1[k]);
      if (m_r_valid) chk($sformatf("rr_s_r_valid[%0d]", k), s_r_valid, (k == 8) ? 2'b10 : 2'b01);
      tick();
    end
    s_ar_valid = 2'b00;
    for (int j = 0; j < 8; j++) begin
      m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = (j < 4) ? 6'h0A : 6'h2B;
      @(negedge clk);
      chk("drain_s_r_valid", s_r_valid, (j < 4) ? 2'b01 : 2'b10);
      tick();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    chk("drain_cnt0", dut.r_cnt[0], 0);
    chk("drain_cnt1", dut.r_cnt[1], 0);
    chk("drain_m_ar_valid", m_ar_valid, 0);
    tick();
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 6'h21;
`ifdef DDR_RD_ARB_ERR_EN
    s_r_ready = 2'b00;
    @(negedge clk);
    chk("orph_s_r_valid", s_r_valid, 2'b00);
    chk("orph_m_r_ready", m_r_ready, 1);
    chk("orph_err_before", err_o, 0);
    tick(); m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    chk("orph_err", err_o, 1);
`else
    s_r_ready = 2'b10;
    @(negedge clk);
    chk("orph_s_r_valid", s_r_valid, 2'b10);
    chk("orph_s_r_id", s_r_id, 5'h01);
    chk("orph_m_r_ready", m_r_ready, 1);
    tick(); m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    chk("orph_err", err_o, 0);
`endif
    chk("orph_cnt1", dut.r_cnt[1], 0);
    tick();
    m_ar_ready = 1'b0; s_ar_valid = 2'b01;
    tick(); s_ar_valid = 2'b00;
    #1;
    chk("pre_rst_cnt0", dut.r_cnt[0], 1);
    rst = 1'b1;
    #1;
    chk("async_rst_m_ar_valid", m_ar_valid, 0);
    chk("async_rst_cnt0", dut.r_cnt[0], 0);
    tick(); rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
